// File: rtl/nf10_axis_memcached_lanebuffer_if.sv
// nf10_axis_memcached_lanebuffer_if: write-side word stream bundle for the lane buffer
// Signals: wr_data (LANE_W), wr_valid, wr_ready, wr_last, wr_abort
// master: producer drives data/valid/last/abort and samples wr_ready
// slave:  buffer samples data/valid/last/abort and drives wr_ready
interface nf10_axis_memcached_lanebuffer_if #(parameter int LANE_W = 32);
    logic [LANE_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic              wr_last;
    logic              wr_abort;
    modport master (output wr_data, wr_valid, wr_last, wr_abort, input wr_ready);
    modport slave (input wr_data, wr_valid, wr_last, wr_abort, output wr_ready);
endinterface

// File: rtl/nf10_axis_memcached_lanebuffer.sv
// nf10_axis_memcached_lanebuffer: single-frame assembly buffer, narrow stream in, wide row + narrow random reads out
// Ports: ACLK, ARESET (async, active-high); wr (slave stream: data/valid/ready/last/abort);
//        rel releases the held frame; frame_valid/frame_err/wr_count report frame status;
//        rdw_addr -> rdw_data (one row, lane 0 in LSBs); rdn_addr {row,lane} -> rdn_data.
// Option: NF10_LANEBUF_ZERO_PAD_EN masks read lanes at or beyond wr_count to zero.
module nf10_axis_memcached_lanebuffer #(
    parameter int LANES     = 2,
    parameter int LANE_BITS = 1,
    parameter int LANE_W    = 32,
    parameter int DEPTH     = 190,
    parameter int AW        = 8
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    nf10_axis_memcached_lanebuffer_if.slave wr,
    input  logic                          rel,
    output logic                          frame_valid,
    output logic                          frame_err,
    output logic [AW+LANE_BITS:0]         wr_count,
    input  logic [AW-1:0]                 rdw_addr,
    output logic [LANES*LANE_W-1:0]       rdw_data,
    input  logic [AW+LANE_BITS-1:0]       rdn_addr,
    output logic [LANE_W-1:0]             rdn_data
);
    localparam int CW = AW + LANE_BITS + 1;
    localparam logic [CW-1:0] CAP = CW'(DEPTH * LANES);
    typedef enum logic [1:0] {IDLE, FILL, DRAIN, HELD} state_t;
    state_t                  state_q, state_d;
    logic [CW-1:0]           wr_count_q, wr_count_d;
    logic                    frame_err_q, frame_err_d;
    logic [AW-1:0]           rdw_addr_q, rdw_addr_d;
    logic [AW+LANE_BITS-1:0] rdn_addr_q, rdn_addr_d;
    logic                    beat, we;
    logic [AW-1:0]           wr_row;
    logic [LANE_BITS-1:0]    wr_lane;
    logic [LANE_W-1:0]       rdn_lane [LANES];
    logic [LANE_W-1:0]       rdn_raw;
    // ready must drop while reset is held, even though the state already reads IDLE
    assign wr.wr_ready  = (state_q != HELD) && !ARESET;
    assign beat         = wr.wr_valid && wr.wr_ready;
    assign frame_valid  = state_q == HELD;
    assign frame_err    = frame_err_q;
    assign wr_count     = wr_count_q;
    // wr_count is also the narrow index of the next word to store
    assign wr_row       = wr_count_q[CW-2:LANE_BITS];
    assign wr_lane      = wr_count_q[LANE_BITS-1:0];
    always_comb begin
        state_d     = state_q;
        wr_count_d  = wr_count_q;
        frame_err_d = frame_err_q;
        we          = 1'b0;
        rdw_addr_d  = rdw_addr;
        rdn_addr_d  = rdn_addr;
        case (state_q)
            IDLE: if (beat) begin
                we         = 1'b1;
                wr_count_d = CW'(1);
                state_d    = wr.wr_last ? HELD : FILL;
            end
            FILL: if (wr.wr_abort) begin
                state_d     = IDLE;
                wr_count_d  = '0;
                frame_err_d = 1'b0;
            end else if (beat) begin
                if (wr_count_q < CAP) begin
                    we         = 1'b1;
                    wr_count_d = wr_count_q + CW'(1);
                    state_d    = wr.wr_last ? HELD : FILL;
                end else begin
                    state_d     = wr.wr_last ? HELD : DRAIN;
                    frame_err_d = wr.wr_last;
                end
            end
            DRAIN: if (wr.wr_abort) begin
                state_d     = IDLE;
                wr_count_d  = '0;
                frame_err_d = 1'b0;
            end else if (beat && wr.wr_last) begin
                state_d     = HELD;
                frame_err_d = 1'b1;
            end
            HELD: if (rel) begin
                state_d     = IDLE;
                wr_count_d  = '0;
                frame_err_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= IDLE;
            wr_count_q  <= '0;
            frame_err_q <= 1'b0;
            rdw_addr_q  <= '0;
            rdn_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_count_q  <= wr_count_d;
            frame_err_q <= frame_err_d;
            rdw_addr_q  <= rdw_addr_d;
            rdn_addr_q  <= rdn_addr_d;
        end
    end
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [LANE_W-1:0] mem [DEPTH];
        logic [LANE_W-1:0] rdw_raw;
        always_ff @(posedge ACLK) begin
            if (we && wr_lane == LANE_BITS'(g)) mem[wr_row] <= wr.wr_data;
        end
        assign rdw_raw     = mem[rdw_addr_q];
        assign rdn_lane[g] = mem[rdn_addr_q[AW+LANE_BITS-1:LANE_BITS]];
`ifdef NF10_LANEBUF_ZERO_PAD_EN
        assign rdw_data[g*LANE_W +: LANE_W] = ({1'b0, rdw_addr_q, LANE_BITS'(g)} < wr_count_q) ? rdw_raw : '0;
`else
        assign rdw_data[g*LANE_W +: LANE_W] = rdw_raw;
`endif
    end
    assign rdn_raw = rdn_lane[rdn_addr_q[LANE_BITS-1:0]];
`ifdef NF10_LANEBUF_ZERO_PAD_EN
    assign rdn_data = ({1'b0, rdn_addr_q} < wr_count_q) ? rdn_raw : '0;
`else
    assign rdn_data = rdn_raw;
`endif
endmodule
